// File: rtl/path_output_ctrl_pkg.sv
// Shared router definitions used by the path input and output controllers.
package path_output_ctrl_pkg;

   // Default packet width shared by every controller on the path.
   localparam int DATA_W_DEF = 64;

   // Virtual-channel tag lives in the packet MSB.
   localparam int VC_BIT = DATA_W_DEF - 1;

   // Hop-count field bounds; adjusted upstream, carried through untouched here.
   localparam int HOP_HI = 55;
   localparam int HOP_LO = 48;

   // Virtual-channel encodings.
   localparam logic VC_EVEN = 1'b0;
   localparam logic VC_ODD  = 1'b1;

endpackage

// File: rtl/path_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping), pointer moves past the winner after each grant.
module path_rr_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   output logic [N_REQ-1:0] gnt
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr_p1;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;
   logic [PTR_W-1:0] sel;
   logic             found;

   // Search from the pointer upward with wrap-around; first hit wins.
   always_comb begin
      gnt   = '0;
      sum   = '0;
      idx   = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr_p1} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N_REQ))
            sum = sum - (PTR_W+1)'(N_REQ);
         idx = sum[PTR_W-1:0];
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            sel      = idx;
            found    = 1'b1;
         end
      end
   end

   // Pointer advances past the granted requester; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst)
         ptr_p1 <= '0;
      else if (found)
         ptr_p1 <= (sel == PTR_W'(N_REQ-1)) ? '0 : sel + 1'b1;
   end

endmodule

// File: rtl/path_output_ctrl.sv
// Router output-channel controller: arbitrates forward requests, captures the
// winner into the even/odd VC entry selected by polarity, and presents the
// opposite entry on the outgoing channel with a polarity-gated handshake.
module path_output_ctrl
   import path_output_ctrl_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    polarity,
   input  logic [N_REQ-1:0]        in2out_req,
   output logic [N_REQ-1:0]        out2in_gnt,
   input  logic [N_REQ*DATA_W-1:0] in2out_din,
   output logic                    out2ch_vld,
   input  logic                    ch2out_rdy,
   output logic [DATA_W-1:0]       out2ch_dout
);

   // Write side fills the entry upstream is forwarding; read side presents the other.
   logic wvc;
   logic rvc;
   assign wvc = ~polarity;
   assign rvc = polarity;

   logic [1:0]        buf_empty_p1;
   logic [DATA_W-1:0] vc_buf_p1 [2];
   logic [DATA_W-1:0] wdata;
   logic              wr_en;
   logic              drain;

   path_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (in2out_req),
      .en  (buf_empty_p1[wvc]),
      .gnt (out2in_gnt)
   );

   assign wr_en = |out2in_gnt;

   // Select the granted requester's packet (grant is one-hot or zero).
   always_comb begin
      wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (out2in_gnt[i])
            wdata = in2out_din[i*DATA_W +: DATA_W];
      end
   end

   assign out2ch_vld  = ~buf_empty_p1[rvc];
   assign out2ch_dout = out2ch_vld ? vc_buf_p1[rvc] : '0;
   assign drain       = out2ch_vld & ch2out_rdy;

   // Occupancy: write and drain always target different entries, so both apply.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_empty_p1 <= 2'b11;
      end else begin
         if (wr_en)
            buf_empty_p1[wvc] <= 1'b0;
         if (drain)
            buf_empty_p1[rvc] <= 1'b1;
      end
   end

   // Packet storage; contents are qualified by occupancy so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en)
         vc_buf_p1[wvc] <= wdata;
   end

endmodule

// File: tb/tb_path_output_ctrl.sv
// Scoreboard bench for path_output_ctrl with a behavioural reference model.
module tb_path_output_ctrl;

   localparam int N_REQ  = 2;
   localparam int DATA_W = 64;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    polarity;
   logic [N_REQ-1:0]        in2out_req;
   logic [N_REQ-1:0]        out2in_gnt;
   logic [N_REQ*DATA_W-1:0] in2out_din;
   logic                    out2ch_vld;
   logic                    ch2out_rdy;
   logic [DATA_W-1:0]       out2ch_dout;

   path_output_ctrl #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .polarity    (polarity),
      .in2out_req  (in2out_req),
      .out2in_gnt  (out2in_gnt),
      .in2out_din  (in2out_din),
      .out2ch_vld  (out2ch_vld),
      .ch2out_rdy  (ch2out_rdy),
      .out2ch_dout (out2ch_dout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: occupancy per VC, round-robin pointer, expected packets per VC.
   bit          m_full [2];
   int          m_ptr;
   logic [63:0] q_even [$];
   logic [63:0] q_odd  [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: entered just after a rising edge, leaves just after the next.
   task automatic cycle(input logic pol, input logic [1:0] rq,
                        input logic [63:0] d0, input logic [63:0] d1, input logic rd);
      int          g;
      logic        wv;
      logic [1:0]  eg;
      polarity   = pol;
      in2out_req = rq;
      in2out_din = {d1, d0};
      ch2out_rdy = rd;
      wv = ~pol;
      g  = -1;
      if (!m_full[wv]) begin
         for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_ptr + k) % N_REQ;
            if (g < 0 && rq[c]) g = c;
         end
      end
      eg = (g >= 0) ? 2'(1 << g) : 2'b00;
      #1;
      check("gnt", 64'(out2in_gnt), 64'(eg));
      check("vld", 64'(out2ch_vld), 64'(m_full[pol]));
      @(posedge clk);
      if (m_full[pol] && rd) m_full[pol] = 0;
      if (g >= 0) begin
         m_full[wv] = 1;
         if (wv) q_odd.push_back(g == 0 ? d0 : d1);
         else    q_even.push_back(g == 0 ? d0 : d1);
         m_ptr = (g + 1) % N_REQ;
      end
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in2out_req = '0;
      ch2out_rdy = 1'b0;
      @(posedge clk);
      m_full[0] = 0;
      m_full[1] = 0;
      m_ptr     = 0;
      q_even.delete();
      q_odd.delete();
      #1;
      rst = 1'b0;
      polarity = 1'b0;
      #1;
      check("rst_vld0", 64'(out2ch_vld), 64'd0);
      check("rst_dout0", out2ch_dout, 64'd0);
      polarity = 1'b1;
      #1;
      check("rst_vld1", 64'(out2ch_vld), 64'd0);
      check("rst_dout1", out2ch_dout, 64'd0);
      check("rst_gnt", 64'(out2in_gnt), 64'd0);
   endtask

   // Monitor: whenever the channel presents a packet, compare with the scoreboard.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (out2ch_vld) begin
            if ((polarity ? q_odd.size() : q_even.size()) == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_vld actual=1 expected=0 at %0t", $time);
            end else begin
               check("dout", out2ch_dout, polarity ? q_odd[0] : q_even[0]);
               if (ch2out_rdy) begin
                  if (polarity) void'(q_odd.pop_front());
                  else          void'(q_even.pop_front());
               end
            end
         end else begin
            check("dout_idle", out2ch_dout, 64'd0);
         end
      end
   end

   // Upstream protocol: a granted packet must carry the VC bit of the write entry.
   always @(negedge clk) begin
      if (rst !== 1'b1 && |out2in_gnt) begin
         for (int i = 0; i < N_REQ; i++)
            if (out2in_gnt[i])
               assert (in2out_din[i*DATA_W + DATA_W - 1] == ~polarity)
                  else $error("vc bit mismatch on requester %0d", i);
      end
   end

   function automatic logic [63:0] rnd_pkt(input logic vc);
      logic [63:0] p;
      p = {$urandom, $urandom};
      p[63] = vc;
      return p;
   endfunction

   initial begin
      rst        = 1'b1;
      polarity   = 1'b0;
      in2out_req = '0;
      in2out_din = '0;
      ch2out_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Single packet through even entry, drained at polarity 0.
      cycle(1, 2'b01, 64'h0012_3400_0000_0001, 64'h0, 1);
      cycle(0, 2'b00, 64'h0, 64'h0, 1);
      cycle(0, 2'b00, 64'h0, 64'h0, 1);

      // Round-robin fairness with both requesting at polarity 1.
      for (int n = 0; n < 3; n++) begin
         cycle(1, 2'b11, rnd_pkt(0), rnd_pkt(0), 1);
         cycle(0, 2'b00, 64'h0, 64'h0, 1);
      end

      // Even entry full blocks grant until drained.
      cycle(1, 2'b01, rnd_pkt(0), 64'h0, 0);
      cycle(0, 2'b00, 64'h0, 64'h0, 0);
      cycle(1, 2'b01, rnd_pkt(0), 64'h0, 0);
      cycle(0, 2'b00, 64'h0, 64'h0, 1);
      cycle(1, 2'b01, rnd_pkt(0), 64'h0, 0);
      cycle(0, 2'b00, 64'h0, 64'h0, 1);

      // Odd entry held under back-pressure across polarity flips.
      cycle(0, 2'b01, 64'h8000_0000_0000_00AA, 64'h0, 0);
      for (int n = 0; n < 4; n++) cycle(n[0] ? 1'b0 : 1'b1, 2'b00, 64'h0, 64'h0, 0);
      cycle(1, 2'b00, 64'h0, 64'h0, 1);
      cycle(1, 2'b00, 64'h0, 64'h0, 0);

      // Simultaneous drain of even and capture into odd.
      cycle(1, 2'b01, rnd_pkt(0), 64'h0, 0);
      cycle(0, 2'b10, 64'h0, rnd_pkt(1), 1);
      cycle(1, 2'b00, 64'h0, 64'h0, 1);
      cycle(0, 2'b00, 64'h0, 64'h0, 1);

      // Both entries full, pointer at 1, then reset mid-operation.
      cycle(1, 2'b01, rnd_pkt(0), 64'h0, 0);
      cycle(0, 2'b01, rnd_pkt(1), 64'h0, 0);
      do_reset();
      #8;
      cycle(1, 2'b11, rnd_pkt(0), rnd_pkt(0), 0);

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 600; n++) begin
         logic p;
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
            #8;
         end
         p = 1'($urandom);
         cycle(p, 2'($urandom), rnd_pkt(~p), rnd_pkt(~p), $urandom_range(0, 9) < 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
